// File: rtl/target_pkg.sv
// Shared constants and FSM state encoding for the PCI target slice.
package target_pkg;

  localparam logic [3:0]  CMD_READ  = 4'b0110;
  localparam logic [3:0]  CMD_WRITE = 4'b0111;
  localparam int unsigned MEM_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_DATA,
    READ_TA,
    READ_DATA
  } state_t;

endpackage

// File: rtl/target_mem.sv
// Word storage with per-byte write enables, asynchronous read and asynchronous clear.
module target_mem import target_pkg::*; #(
  parameter int unsigned DEPTH = MEM_DEPTH,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/target.sv
// PCI-style memory target: claims every address, supports burst read/write with
// wait states, byte-enabled writes and index wrap-around.
module target import target_pkg::*; #(
  parameter int unsigned MEM_DEPTH = target_pkg::MEM_DEPTH,
  parameter logic [3:0]  CMD_READ  = target_pkg::CMD_READ,
  parameter logic [3:0]  CMD_WRITE = target_pkg::CMD_WRITE
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Frame,
  input  logic        IRDY,
  input  logic [3:0]  CBE,
  input  logic        oe,
  inout  wire  [31:0] AddressDataLine,
  output logic        DEVSEL,
  output logic        TRDY
);

  localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t        state;
  logic [IW-1:0] index;
  logic [IW-1:0] index_next;
  logic [31:0]   data;
  logic [31:0]   rdata;
  logic [IW-1:0] raddr;
  logic [3:0]    we;
  logic          xfer;

  assign xfer       = !IRDY && !TRDY;
  assign index_next = (index == IW'(MEM_DEPTH - 1)) ? '0 : index + 1'b1;
  // In READ_DATA the register is refilled with the word after the one just transferred.
  assign raddr      = (state == READ_DATA) ? index_next : index;
  assign we         = (state == WRITE_DATA && xfer) ? ~CBE : 4'b0000;

  assign AddressDataLine = (state == READ_DATA && !oe) ? data : 32'bz;

  target_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (IW)
  ) u_mem (
    .clk   (Clk),
    .rst   (Rst),
    .we    (we),
    .waddr (index),
    .wdata (AddressDataLine),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      index  <= '0;
      data   <= '0;
      DEVSEL <= 1'b1;
      TRDY   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          DEVSEL <= 1'b1;
          TRDY   <= 1'b1;
          if (!Frame) begin
            index <= AddressDataLine[IW-1:0];
            if (CBE == CMD_WRITE) begin
              state  <= WRITE_DATA;
              DEVSEL <= 1'b0;
              TRDY   <= 1'b0;
            end else if (CBE == CMD_READ) begin
              state  <= READ_TA;
              DEVSEL <= 1'b0;
            end
          end
        end
        WRITE_DATA: begin
          if (xfer) begin
            index <= index_next;
            if (Frame) begin
              state  <= IDLE;
              DEVSEL <= 1'b1;
              TRDY   <= 1'b1;
            end
          end
        end
        READ_TA: begin
          state <= READ_DATA;
          TRDY  <= 1'b0;
          data  <= rdata;
        end
        READ_DATA: begin
          if (xfer) begin
            index <= index_next;
            data  <= rdata;
            if (Frame) begin
              state  <= IDLE;
              DEVSEL <= 1'b1;
              TRDY   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target.sv
// Scoreboard bench for target: a byte-merging memory model predicts read data,
// which a negedge monitor compares against the bus on every read transfer.
module tb_target;
  import target_pkg::*;

  localparam int DEPTH = 8;

  logic        Clk;
  logic        Rst;
  logic        Frame;
  logic        IRDY;
  logic [3:0]  CBE;
  logic        oe;
  logic [31:0] ad_drv;
  wire  [31:0] ad;
  logic        DEVSEL;
  logic        TRDY;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] wd [8];
  logic [3:0]  wb [8];

  assign ad = oe ? ad_drv : 32'bz;

  target dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Frame           (Frame),
    .IRDY            (IRDY),
    .CBE             (CBE),
    .oe              (oe),
    .AddressDataLine (ad),
    .DEVSEL          (DEVSEL),
    .TRDY            (TRDY)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Read transfers happen on the next rising edge; sample the bus mid-cycle.
  always @(negedge Clk) begin
    if (!Rst && !oe && !IRDY && !TRDY && !DEVSEL) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", ad, 32'hxxxxxxxx);
      end else begin
        check("rd_data", ad, exp_q.pop_front());
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic addr_phase(input logic [3:0] cmd, input int idx);
    @(posedge Clk); #1;
    check("idle_devsel", {31'b0, DEVSEL}, 32'd1);
    check("idle_trdy", {31'b0, TRDY}, 32'd1);
    Frame  = 1'b0;
    IRDY   = 1'b1;
    oe     = 1'b1;
    CBE    = cmd;
    ad_drv = 32'hFFFF_FFF8 | 32'(idx);
  endtask

  task automatic idle();
    @(posedge Clk); #1;
    Frame = 1'b1;
    IRDY  = 1'b1;
    oe    = 1'b0;
    check("end_devsel", {31'b0, DEVSEL}, 32'd1);
    check("end_trdy", {31'b0, TRDY}, 32'd1);
  endtask

  task automatic write_burst(input int idx, input int n);
    int cur;
    addr_phase(CMD_WRITE, idx);
    cur = idx;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      if (i == 0) begin
        check("wr_devsel", {31'b0, DEVSEL}, 32'd0);
        check("wr_trdy", {31'b0, TRDY}, 32'd0);
      end
      Frame  = (i == n - 1);
      IRDY   = 1'b0;
      oe     = 1'b1;
      ad_drv = wd[i];
      CBE    = wb[i];
      for (int b = 0; b < 4; b++) begin
        if (!wb[i][b]) model[cur][8*b +: 8] = wd[i][8*b +: 8];
      end
      cur = (cur + 1) % DEPTH;
    end
  endtask

  task automatic read_burst(input int idx, input int n, input int wait_at);
    int cur;
    addr_phase(CMD_READ, idx);
    @(posedge Clk); #1;
    Frame = 1'b0;
    IRDY  = 1'b1;
    oe    = 1'b0;
    CBE   = 4'b0000;
    check("ta_devsel", {31'b0, DEVSEL}, 32'd0);
    check("ta_trdy", {31'b0, TRDY}, 32'd1);
    cur = idx;
    for (int i = 0; i < n; i++) begin
      if (i == wait_at) begin
        @(posedge Clk); #1;
        IRDY = 1'b1;
        Frame = 1'b0;
        check("rd_hold", ad, model[cur]);
        check("rd_wait_devsel", {31'b0, DEVSEL}, 32'd0);
      end
      @(posedge Clk); #1;
      IRDY  = 1'b0;
      Frame = (i == n - 1);
      CBE   = 4'(i * 5);
      exp_q.push_back(model[cur]);
      cur = (cur + 1) % DEPTH;
    end
  endtask

  initial begin
    Rst = 1'b1; Frame = 1'b1; IRDY = 1'b1; CBE = 4'b1111; oe = 1'b0; ad_drv = '0;
    clear_model();
    #2;
    check("rst_devsel", {31'b0, DEVSEL}, 32'd1);
    check("rst_trdy", {31'b0, TRDY}, 32'd1);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Byte-enabled writes, then read back.
    wd[0] = 32'h12345678; wb[0] = 4'b0011;
    wd[1] = 32'h33345633; wb[1] = 4'b1001;
    wd[2] = 32'h44442222; wb[2] = 4'b1100;
    wd[3] = 32'h55555555; wb[3] = 4'b1111;
    write_burst(0, 4);
    idle();
    read_burst(0, 4, -1);
    idle();

    // Unsupported command is not claimed.
    addr_phase(4'b0000, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      Frame = (i == 2); IRDY = 1'b0; ad_drv = 32'hDEAD_BEEF; CBE = 4'b0000;
      check("unsup_devsel", {31'b0, DEVSEL}, 32'd1);
      check("unsup_trdy", {31'b0, TRDY}, 32'd1);
    end
    idle();
    read_burst(0, 4, -1);
    idle();

    // Wrap-around write from index 5, then full read with a wait state.
    for (int i = 0; i < 6; i++) begin
      wd[i] = 32'hA5000000 + 32'(i * 32'h0101_0101);
      wb[i] = 4'b0000;
    end
    write_burst(5, 6);
    idle();
    read_burst(0, 8, 2);
    idle();

    // Back-to-back write, write, read.
    wd[0] = 32'h1111_1111; wb[0] = 4'b1110;
    wd[1] = 32'h2222_2222; wb[1] = 4'b0101;
    wd[2] = 32'h3333_3333; wb[2] = 4'b0000;
    write_burst(2, 3);
    wd[0] = 32'hCCCC_CCCC; wb[0] = 4'b0111;
    wd[1] = 32'hDDDD_DDDD; wb[1] = 4'b1010;
    write_burst(1, 2);
    read_burst(0, 8, -1);
    idle();

    // Reset in the middle of a write burst.
    addr_phase(CMD_WRITE, 3);
    @(posedge Clk); #1;
    Frame = 1'b0; IRDY = 1'b1; ad_drv = 32'hFFFF_FFFF; CBE = 4'b0000;
    check("pre_rst_devsel", {31'b0, DEVSEL}, 32'd0);
    #2;
    Rst = 1'b1;
    #1;
    check("async_rst_devsel", {31'b0, DEVSEL}, 32'd1);
    check("async_rst_trdy", {31'b0, TRDY}, 32'd1);
    clear_model();
    @(posedge Clk); #1;
    Rst = 1'b0; Frame = 1'b1; IRDY = 1'b1; oe = 1'b0;
    read_burst(4, 8, -1);
    idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("timeout", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
